// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared constants for the data-memory controller.
//   - Access size encodings as seen on the pN_size ports.
//   - Controller state encoding.
//   - access_illegal(): size/alignment legality check used at grant time.
package dmem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RMW,
        S_RESP
    } state_e;

    // Size 11 is illegal; halves need addr[0] = 0, words need addr[1:0] = 0.
    function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_ctrl_lane_unit.sv
// dmem_lane_unit: combinational byte-lane logic for the data-memory controller.
//   word    : current memory word (mem_rd)
//   wdata   : right-aligned store data
//   size    : access size (byte/half/word)
//   addr_lo : byte offset within the word
//   uns     : 1 = zero-extend loads, 0 = sign-extend
//   merged  : word with the addressed lane(s) replaced by wdata
//   rdata   : extracted and extended load data
module dmem_lane_unit
    import dmem_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [XLEN-1:0] wdata,
    input  logic [1:0]      size,
    input  logic [1:0]      addr_lo,
    input  logic            uns,
    output logic [XLEN-1:0] merged,
    output logic [XLEN-1:0] rdata
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: merged[{addr_lo, 3'b000} +: 8]  = wdata[7:0];
            SZ_HALF: merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

    always_comb begin
        lane_b = word[{addr_lo, 3'b000} +: 8];
        lane_h = word[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: rdata = {{(XLEN-8){~uns & lane_b[7]}}, lane_b};
            SZ_HALF: rdata = {{(XLEN-16){~uns & lane_h[15]}}, lane_h};
            default: rdata = word;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: shares a single-port, word-write-only data memory between two
// requesters (p0 = CPU MEM stage, p1 = debug/loader) and builds byte/half
// stores as read-modify-write sequences.
//   clk, reset              : clock, synchronous active-high reset
//   pN_req/we/addr/wdata/
//   pN_size/uns             : request (held until pN_ack)
//   pN_ack/rdata/err        : one-cycle completion pulse with load data / error
//   mem_we/mem_a/mem_wd     : word write port to dmem
//   mem_rd                  : combinational dmem read data at mem_a
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [XLEN-1:0]   p0_wdata,
    input  logic [1:0]        p0_size,
    input  logic              p0_uns,
    output logic              p0_ack,
    output logic [XLEN-1:0]   p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [XLEN-1:0]   p1_wdata,
    input  logic [1:0]        p1_size,
    input  logic              p1_uns,
    output logic              p1_ack,
    output logic [XLEN-1:0]   p1_rdata,
    output logic              p1_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [XLEN-1:0]   mem_wd,
    input  logic [XLEN-1:0]   mem_rd
);

    state_e            state;
    logic              last_grant;

    logic              gnt_valid;
    logic              gnt_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [XLEN-1:0]   sel_wdata;
    logic [1:0]        sel_size;
    logic              sel_uns;
    logic              sel_err;

    logic [ADDR_W-1:0] l_addr;
    logic [XLEN-1:0]   l_wdata;
    logic [1:0]        l_size;
    logic              l_uns;
    logic              l_id;

    logic [ADDR_W-1:0] cur_addr;
    logic [XLEN-1:0]   cur_wdata;
    logic [1:0]        cur_size;
    logic              cur_uns;
    logic [XLEN-1:0]   merged;
    logic [XLEN-1:0]   ext;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        gnt_valid = p0_req | p1_req;
        if (p0_req && p1_req) gnt_id = ~last_grant;
        else                  gnt_id = p1_req;
        sel_we    = gnt_id ? p1_we    : p0_we;
        sel_addr  = gnt_id ? p1_addr  : p0_addr;
        sel_wdata = gnt_id ? p1_wdata : p0_wdata;
        sel_size  = gnt_id ? p1_size  : p0_size;
        sel_uns   = gnt_id ? p1_uns   : p0_uns;
        sel_err   = access_illegal(sel_size, sel_addr[1:0]);
    end

    // The lane unit works on the live request in IDLE and on the latched one
    // afterwards, so one instance serves both the grant and the RMW cycle.
    always_comb begin
        if (state == S_IDLE) begin
            cur_addr  = sel_addr;
            cur_wdata = sel_wdata;
            cur_size  = sel_size;
            cur_uns   = sel_uns;
        end else begin
            cur_addr  = l_addr;
            cur_wdata = l_wdata;
            cur_size  = l_size;
            cur_uns   = l_uns;
        end
    end

    dmem_lane_unit #(.XLEN(XLEN)) u_lane (
        .word    (mem_rd),
        .wdata   (cur_wdata),
        .size    (cur_size),
        .addr_lo (cur_addr[1:0]),
        .uns     (cur_uns),
        .merged  (merged),
        .rdata   (ext)
    );

    assign mem_a  = cur_addr;
    assign mem_wd = merged;

    // Reset gates the write directly so an in-flight RMW never commits.
    always_comb begin
        mem_we = 1'b0;
        if (!reset) begin
            case (state)
                S_IDLE:  mem_we = gnt_valid && sel_we && !sel_err && (sel_size == SZ_WORD);
                S_RMW:   mem_we = 1'b1;
                default: mem_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            p0_ack     <= 1'b0;
            p0_err     <= 1'b0;
            p0_rdata   <= '0;
            p1_ack     <= 1'b0;
            p1_err     <= 1'b0;
            p1_rdata   <= '0;
            l_addr     <= '0;
            l_wdata    <= '0;
            l_size     <= SZ_BYTE;
            l_uns      <= 1'b0;
            l_id       <= 1'b0;
        end else begin
            p0_ack   <= 1'b0;
            p0_err   <= 1'b0;
            p0_rdata <= '0;
            p1_ack   <= 1'b0;
            p1_err   <= 1'b0;
            p1_rdata <= '0;
            case (state)
                S_IDLE: begin
                    if (gnt_valid) begin
                        last_grant <= gnt_id;
                        l_addr     <= sel_addr;
                        l_wdata    <= sel_wdata;
                        l_size     <= sel_size;
                        l_uns      <= sel_uns;
                        l_id       <= gnt_id;
                        if (sel_err || !sel_we || sel_size == SZ_WORD) begin
                            state <= S_RESP;
                            if (gnt_id) begin
                                p1_ack   <= 1'b1;
                                p1_err   <= sel_err;
                                p1_rdata <= (sel_err || sel_we) ? '0 : ext;
                            end else begin
                                p0_ack   <= 1'b1;
                                p0_err   <= sel_err;
                                p0_rdata <= (sel_err || sel_we) ? '0 : ext;
                            end
                        end else begin
                            state <= S_RMW;
                        end
                    end
                end
                S_RMW: begin
                    state <= S_RESP;
                    if (l_id) p1_ack <= 1'b1;
                    else      p0_ack <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
